// File: rtl/controle_tiros_pkg.sv
// Shared types for the shot controller: slot encodings, FSM states, request kinds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package controle_tiros_pkg;

    localparam int N_SLOTS = 16;
    localparam int ADDR_W  = 4;
    localparam int MUN_W   = 5;

    // Slot RAM contents; RESERVADO never matches any search target.
    typedef enum logic [1:0] {
        VAZIO     = 2'b00,
        ATIVO     = 2'b01,
        CARREGADO = 2'b10,
        RESERVADO = 2'b11
    } slot_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SCAN,
        RD,
        CHECK,
        WRITE,
        FAIL
    } estado_t;

    typedef enum logic [1:0] {
        PED_NENHUM,
        PED_DISPARO,
        PED_RECARGA,
        PED_REMOVER
    } pedido_t;

    // Slot state a scan looks for: a fire consumes a loaded slot, a recharge fills an empty one.
    function automatic slot_t alvo_busca(input pedido_t p);
        return (p == PED_DISPARO) ? CARREGADO : VAZIO;
    endfunction

    // Value written back when a transaction succeeds.
    function automatic slot_t dado_escrita(input pedido_t p);
        case (p)
            PED_DISPARO: return ATIVO;
            PED_RECARGA: return CARREGADO;
            default:     return VAZIO;
        endcase
    endfunction

endpackage

// File: rtl/controle_tiros_if.sv
// Request, slot-RAM and status signals of the shot controller in one bundle.
// Latency: n/a (wires only).
// Backpressure: none; requests are one-cycle pulses latched by the controller.
interface controle_tiros_if;
    import controle_tiros_pkg::*;

    logic              disparo;
    logic              recarga;
    logic              remover;
    logic [ADDR_W-1:0] remover_idx;
    slot_t             mem_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    slot_t             mem_data;
    logic              tiro_ok;
    logic [ADDR_W-1:0] tiro_idx;
    logic              tiro_negado;
    logic              remover_ok;
    logic              erro;
    logic [MUN_W-1:0]  municao;
    logic              pronto;

    // Requester side, which also models the external slot RAM.
    modport master (
        output disparo, recarga, remover, remover_idx, mem_q,
        input  mem_we, mem_addr, mem_data, tiro_ok, tiro_idx, tiro_negado,
               remover_ok, erro, municao, pronto
    );

    // Controller side.
    modport slave (
        input  disparo, recarga, remover, remover_idx, mem_q,
        output mem_we, mem_addr, mem_data, tiro_ok, tiro_idx, tiro_negado,
               remover_ok, erro, municao, pronto
    );

endinterface

// File: rtl/controle_tiros_registro_pedidos.sv
// Sticky pending flags for fire/recharge/remove, remove-index latch and priority select.
// Latency: a pulse is visible on ped_vld the cycle after it arrives.
// Backpressure: fire/recharge pulses merge; a remove pulse while one is pending is dropped (descartado).
module registro_pedidos
    import controle_tiros_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disparo,
    input  logic              recarga,
    input  logic              remover,
    input  logic [ADDR_W-1:0] remover_idx,
    input  logic              aceita,
    output logic              ped_vld,
    output pedido_t           ped_tipo,
    output logic [ADDR_W-1:0] ped_idx,
    output logic              descartado
);

    logic              pend_disp;
    logic              pend_rec;
    logic              pend_rem;
    logic [ADDR_W-1:0] idx_q;
    logic              tira_disp;
    logic              tira_rec;
    logic              tira_rem;

    // Fixed priority: remove, then fire, then recharge.
    always_comb begin
        ped_tipo = PED_NENHUM;
        if (pend_rem) begin
            ped_tipo = PED_REMOVER;
        end else if (pend_disp) begin
            ped_tipo = PED_DISPARO;
        end else if (pend_rec) begin
            ped_tipo = PED_RECARGA;
        end
    end

    assign ped_vld    = pend_disp | pend_rec | pend_rem;
    assign ped_idx    = idx_q;
    assign tira_disp  = aceita && (ped_tipo == PED_DISPARO);
    assign tira_rec   = aceita && (ped_tipo == PED_RECARGA);
    assign tira_rem   = aceita && (ped_tipo == PED_REMOVER);
    // A remove that is being taken this cycle frees the latch, so a new one is accepted.
    assign descartado = remover && pend_rem && !tira_rem;

    // A new pulse wins over the clear issued when the same kind is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_disp <= 1'b0;
            pend_rec  <= 1'b0;
            pend_rem  <= 1'b0;
            idx_q     <= '0;
        end else begin
            pend_disp <= (pend_disp && !tira_disp) || disparo;
            pend_rec  <= (pend_rec && !tira_rec) || recarga;
            pend_rem  <= (pend_rem && !tira_rem) || remover;
            if (remover && !descartado) begin
                idx_q <= remover_idx;
            end
        end
    end

endmodule

// File: rtl/controle_tiros.sv
// Shot-slot controller: fire/recharge by lowest-index scan of an external 2-bit slot RAM, remove by index.
// Latency: pulse -> IDLE pick 1 cycle; scan hit at slot j writes 2+j cycles after SCAN entry; remove writes 3 cycles after pick.
// Backpressure: none; requests are latched and serviced one per transaction, excess remove pulses flagged on erro.
module controle_tiros
    import controle_tiros_pkg::*;
#(
    parameter int N_SLOTS = 16,
    parameter int ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    controle_tiros_if.slave bus
);

    localparam int               CNT_W   = $clog2(N_SLOTS) + 1;
    localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(N_SLOTS);
    localparam logic [MUN_W-1:0] MUN_MAX = MUN_W'(N_SLOTS);

    estado_t           estado;
    estado_t           prox_estado;
    logic [CNT_W-1:0]  cnt;
    pedido_t           op;
    logic [ADDR_W-1:0] slot_q;
    logic              init_arm;
    logic [MUN_W-1:0]  municao_q;
    logic [ADDR_W-1:0] tiro_idx_q;

    logic              ped_vld;
    pedido_t           ped_tipo;
    logic [ADDR_W-1:0] ped_idx;
    logic              descartado;
    logic              aceita;
    logic              acerto;
    logic              fim_varredura;
    logic              fim_init;

    logic              mem_we_w;
    logic [ADDR_W-1:0] mem_addr_w;
    slot_t             mem_data_w;
    logic              tiro_ok_w;
    logic              tiro_negado_w;
    logic              remover_ok_w;
    logic              erro_fsm;

    registro_pedidos u_pedidos (
        .clk         (clk),
        .rst_n       (rst_n),
        .disparo     (bus.disparo),
        .recarga     (bus.recarga),
        .remover     (bus.remover),
        .remover_idx (bus.remover_idx),
        .aceita      (aceita),
        .ped_vld     (ped_vld),
        .ped_tipo    (ped_tipo),
        .ped_idx     (ped_idx),
        .descartado  (descartado)
    );

    assign aceita        = (estado == IDLE) && ped_vld;
    // cnt=k compares mem_q for slot k-1, the address presented the cycle before.
    assign acerto        = (cnt != '0) && (bus.mem_q == alvo_busca(op));
    assign fim_varredura = (cnt == CNT_FIM);
    // init_arm holds off the sweep for the first cycle after reset so mem_we reads 0 under reset.
    assign fim_init      = init_arm && (cnt == CNT_ULT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= INIT;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state decode.
    always_comb begin
        prox_estado = estado;
        case (estado)
            INIT:  if (fim_init) prox_estado = IDLE;
            IDLE: begin
                if (ped_vld) begin
                    prox_estado = (ped_tipo == PED_REMOVER) ? RD : SCAN;
                end
            end
            SCAN: begin
                if (acerto) begin
                    prox_estado = WRITE;
                end else if (fim_varredura) begin
                    prox_estado = FAIL;
                end
            end
            RD:    prox_estado = CHECK;
            CHECK: prox_estado = (bus.mem_q == ATIVO) ? WRITE : FAIL;
            WRITE: prox_estado = IDLE;
            FAIL:  prox_estado = IDLE;
            default: prox_estado = INIT;
        endcase
    end

    // Sweep/scan counter, captured request kind and target slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_arm <= 1'b0;
            cnt      <= '0;
            op       <= PED_NENHUM;
            slot_q   <= '0;
        end else begin
            init_arm <= 1'b1;
            case (estado)
                INIT: begin
                    if (init_arm) begin
                        cnt <= fim_init ? '0 : cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    cnt <= '0;
                    if (ped_vld) begin
                        op     <= ped_tipo;
                        slot_q <= ped_idx;
                    end
                end
                SCAN: begin
                    if (acerto) begin
                        slot_q <= ADDR_W'(cnt - CNT_W'(1));
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-state RAM drive and result pulses.
    always_comb begin
        mem_we_w      = 1'b0;
        mem_addr_w    = '0;
        mem_data_w    = VAZIO;
        tiro_ok_w     = 1'b0;
        tiro_negado_w = 1'b0;
        remover_ok_w  = 1'b0;
        erro_fsm      = 1'b0;
        case (estado)
            INIT: begin
                mem_we_w   = init_arm;
                mem_addr_w = cnt[ADDR_W-1:0];
                mem_data_w = init_arm ? CARREGADO : VAZIO;
            end
            SCAN: begin
                mem_addr_w = cnt[ADDR_W-1:0];
            end
            RD, CHECK: begin
                mem_addr_w = slot_q;
            end
            WRITE: begin
                mem_we_w     = 1'b1;
                mem_addr_w   = slot_q;
                mem_data_w   = dado_escrita(op);
                tiro_ok_w    = (op == PED_DISPARO);
                remover_ok_w = (op == PED_REMOVER);
            end
            FAIL: begin
                tiro_negado_w = (op == PED_DISPARO);
                erro_fsm      = (op == PED_REMOVER);
            end
            default: ;
        endcase
    end

    // Loaded-slot count follows every CARREGADO/ATIVO write, clamped to 0..N_SLOTS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            municao_q <= '0;
        end else if (mem_we_w) begin
            if (mem_data_w == CARREGADO && municao_q < MUN_MAX) begin
                municao_q <= municao_q + MUN_W'(1);
            end else if (mem_data_w == ATIVO && municao_q != '0) begin
                municao_q <= municao_q - MUN_W'(1);
            end
        end
    end

    // Last granted slot, held between grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiro_idx_q <= '0;
        end else if (tiro_ok_w) begin
            tiro_idx_q <= slot_q;
        end
    end

    assign bus.mem_we      = mem_we_w;
    assign bus.mem_addr    = mem_addr_w;
    assign bus.mem_data    = mem_data_w;
    assign bus.tiro_ok     = tiro_ok_w;
    assign bus.tiro_idx    = tiro_ok_w ? slot_q : tiro_idx_q;
    assign bus.tiro_negado = tiro_negado_w;
    assign bus.remover_ok  = remover_ok_w;
    assign bus.erro        = erro_fsm | descartado;
    assign bus.municao     = municao_q;
    assign bus.pronto      = (estado == IDLE) && !ped_vld;

endmodule

// File: tb/tb_controle_tiros.sv
// Bench for controle_tiros: directed sequences plus random pulses against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_controle_tiros;
    import controle_tiros_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    controle_tiros_if bus ();

    controle_tiros #(.N_SLOTS(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External slot RAM: synchronous write, registered read.
    slot_t ram [16];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    // Reference model state: slot contents, pending requests, current transaction.
    slot_t m_slot [16];
    bit    m_pd, m_pr, m_pm;
    int    m_pidx;
    int    m_tidx;
    int    m_free;
    bit    m_prev_low = 1'b1;
    int    r_start;
    bit    t_on;
    int    t_kind;   // 1 fire, 2 recharge, 3 remove
    int    t_evt;
    bit    t_hit;
    int    t_slot;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    function automatic int busca(input slot_t alvo);
        for (int i = 0; i < 16; i++) if (m_slot[i] == alvo) return i;
        return -1;
    endfunction

    function automatic int conta_carregados();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_slot[i] == CARREGADO) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic ciclo(input bit d, input bit r, input bit m, input int idx, input bit rst);
        int    e_addr, e_tidx, take, j;
        bit    e_we, e_tok, e_neg, e_rok, e_err, e_pronto, drop, idle, anyp;
        slot_t e_data;
        @(negedge clk);
        rst_n           = rst;
        bus.disparo     = d;
        bus.recarga     = r;
        bus.remover     = m;
        bus.remover_idx = 4'(idx);
        #1;
        e_we = 0; e_addr = 0; e_data = VAZIO; e_tok = 0; e_neg = 0; e_rok = 0;
        e_err = 0; e_pronto = 0; take = 0; drop = 0;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_slot[i] = VAZIO;
            m_pd = 0; m_pr = 0; m_pm = 0; m_pidx = 0; m_tidx = 0;
            t_on = 0; m_free = 32'h7fff_ffff; m_prev_low = 1;
        end else begin
            if (m_prev_low) begin
                r_start    = cyc;
                m_free     = cyc + 17;
                m_prev_low = 0;
            end
            if (cyc > r_start && cyc <= r_start + 16) begin
                e_we = 1; e_addr = cyc - r_start - 1; e_data = CARREGADO;
            end
            idle     = (cyc >= m_free);
            anyp     = m_pd | m_pr | m_pm;
            e_pronto = idle && !anyp;
            if (idle && anyp) begin
                t_on = 1;
                if (m_pm) begin
                    take = 3; t_slot = m_pidx; t_hit = (m_slot[m_pidx] == ATIVO);
                    t_evt = cyc + 3; m_free = cyc + 4;
                end else begin
                    take = m_pd ? 1 : 2;
                    j = busca(take == 1 ? CARREGADO : VAZIO);
                    t_hit = (j >= 0);
                    t_slot = t_hit ? j : 0;
                    t_evt  = t_hit ? cyc + j + 3 : cyc + 18;
                    m_free = t_evt + 1;
                end
                t_kind = take;
            end
            if (t_on && cyc == t_evt) begin
                if (t_hit) begin
                    e_we = 1; e_addr = t_slot;
                    e_data = (t_kind == 1) ? ATIVO : (t_kind == 2) ? CARREGADO : VAZIO;
                    e_tok = (t_kind == 1);
                    e_rok = (t_kind == 3);
                end else begin
                    e_neg = (t_kind == 1);
                    e_err = (t_kind == 3);
                end
            end
            drop = m && m_pm && (take != 3);
            if (drop) e_err = 1;
        end
        e_tidx = e_tok ? t_slot : m_tidx;

        confere("mem_we", bus.mem_we, e_we);
        if (e_we || !rst) confere("mem_addr", bus.mem_addr, e_addr);
        confere("mem_data", bus.mem_data, e_data);
        confere("tiro_ok", bus.tiro_ok, e_tok);
        confere("tiro_idx", bus.tiro_idx, e_tidx);
        confere("tiro_negado", bus.tiro_negado, e_neg);
        confere("remover_ok", bus.remover_ok, e_rok);
        confere("erro", bus.erro, e_err);
        confere("pronto", bus.pronto, e_pronto);
        confere("municao", bus.municao, conta_carregados());

        if (rst) begin
            if (e_we) m_slot[e_addr] = e_data;
            if (e_tok) m_tidx = t_slot;
            if (t_on && cyc == t_evt) t_on = 0;
            if (take == 1) m_pd = 0;
            if (take == 2) m_pr = 0;
            if (take == 3) m_pm = 0;
            if (d) m_pd = 1;
            if (r) m_pr = 1;
            if (m && !drop) begin
                m_pm = 1; m_pidx = idx;
            end
        end
        cyc++;
    endtask

    task automatic espera(input int n);
        repeat (n) ciclo(0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.disparo = 0; bus.recarga = 0; bus.remover = 0; bus.remover_idx = '0;

        // Reset values, then INIT sweep with a fire request latched mid-sweep.
        repeat (3) ciclo(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) ciclo(i == 5, 0, 0, 0, 1);
        espera(4);

        // Successive fires take successive slots.
        repeat (4) begin
            ciclo(1, 0, 0, 0, 1);
            espera(10);
        end

        // Remove an active slot, then the same slot again (now empty).
        ciclo(0, 0, 1, 3, 1); espera(6);
        ciclo(0, 0, 1, 3, 1); espera(6);

        // All three requests in one cycle.
        ciclo(1, 1, 1, 1, 1); espera(60);

        // Second remove while one is still pending is dropped.
        ciclo(1, 0, 0, 0, 1);
        ciclo(0, 0, 1, 2, 1);
        ciclo(0, 0, 1, 2, 1);
        espera(40);

        // Exhaust loaded slots; later fires are refused.
        repeat (18) begin
            ciclo(1, 0, 0, 0, 1);
            espera(22);
        end

        // Reset in the middle of a full-length scan.
        ciclo(1, 0, 0, 0, 1);
        espera(6);
        ciclo(0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 0, 0);
        espera(25);

        // Random request traffic.
        for (int i = 0; i < 1500; i++) begin
            ciclo($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)), 1);
        end
        espera(80);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/controle_tiros.md
CONTROLE_TIROS -- requirements
Module: controle_tiros

Interface
REQ-001 Parameters SHALL be: N_SLOTS, 16, number of shot slots; ADDR_W, 4, slot index width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 disparo  input  1  fire request, one-cycle pulse.
REQ-005 recarga  input  1  recharge tick, one-cycle pulse.
REQ-006 remover  input  1  shot-expired/hit request, one-cycle pulse.
REQ-007 remover_idx  input  4  slot index for remover, sampled with remover.
REQ-008 mem_q  input  2  slot RAM read data; valid the cycle after mem_addr is presented.
REQ-009 mem_we, mem_addr[3:0], mem_data[1:0]  output  slot RAM write enable, address, write data.
REQ-010 tiro_ok  output  1  pulse: fire granted; tiro_idx[3:0] (output) holds the granted slot.
REQ-011 tiro_negado  output  1  pulse: fire refused, no loaded slot.
REQ-012 remover_ok / erro  output  1 each  pulse: remove done / remove rejected or request dropped.
REQ-013 municao  output  5  count of slots in CARREGADO, 0..16.
REQ-014 pronto  output  1  high in IDLE with no pending request.

Function
REQ-015 Slot encoding SHALL be: 00 VAZIO, 01 ATIVO, 10 CARREGADO, 11 reserved (treated as not matching any search).
REQ-016 Each request pulse SHALL set a sticky pending flag, cleared only when serviced; remover also latches remover_idx.
REQ-017 A remover pulse while remover is already pending SHALL be dropped with a one-cycle erro pulse; repeated disparo/recarga pulses SHALL merge into the pending flag.
REQ-018 Service priority from IDLE SHALL be remover > disparo > recarga, one request per transaction.
REQ-019 FSM states SHALL be INIT, IDLE, SCAN, RD, CHECK, WRITE, FAIL.
REQ-020 INIT: write CARREGADO to slots 0..15 on 16 consecutive cycles (mem_we=1), then IDLE with municao=16.
REQ-021 SCAN (disparo: target CARREGADO; recarga: target VAZIO): cycle T+k drives mem_addr=k; cycle T+k+1 compares mem_q for slot k; lowest matching index wins.
REQ-022 On match at slot j, the scan SHALL stop and WRITE SHALL occur at cycle T+j+2 (disparo writes ATIVO, recarga writes CARREGADO).
REQ-023 No match after slot 15: FAIL at T+17; disparo gives a tiro_negado pulse, recarga completes silently; both return to IDLE.
REQ-024 remover: RD drives mem_addr=idx; CHECK next cycle; if ATIVO, WRITE VAZIO and pulse remover_ok; otherwise pulse erro with no write.
REQ-025 tiro_ok and tiro_idx SHALL be asserted in the WRITE cycle of a granted disparo; tiro_idx SHALL hold its value until the next grant.
REQ-026 municao SHALL decrement on each disparo write and increment on each recarga or INIT write, never wrapping.
REQ-027 mem_we SHALL be high only in INIT and WRITE; mem_data SHALL be 00 when mem_we=0.
REQ-028 Requests arriving during INIT or any transaction SHALL be latched and serviced afterward in priority order.

Reset
REQ-029 rst_n low SHALL immediately force INIT with the sweep counter at 0 and clear all pending flags and latched idx.
REQ-030 Reset values SHALL be: mem_we=0, mem_addr=0, mem_data=00, tiro_ok=0, tiro_idx=0, tiro_negado=0, remover_ok=0, erro=0, municao=0, pronto=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no pulse and restart the INIT sweep.

Structure
REQ-032 A shared package SHALL hold the slot encodings, the FSM state enum, N_SLOTS and ADDR_W.
REQ-033 One sub-module, registro_pedidos (pending flags, idx latch, priority select), is natural; the slot RAM remains external.

Verification
REQ-034 Reset release -> 16 INIT writes of 10 to addr 0..15, then pronto=1, municao=16.
REQ-035 disparo after INIT -> WRITE 01 at slot 0 at T+2, tiro_ok with tiro_idx=0, municao=15; second disparo -> slot 1.
REQ-036 16 disparos, then a 17th -> tiro_negado at T+17, no write, municao=0.
REQ-037 remover idx=3 on ATIVO slot -> write 00 at 3, remover_ok; repeat on the same slot -> erro, no write.
REQ-038 disparo, recarga and remover in the same cycle -> remover serviced first, then disparo, then recarga; all complete and none lost.
REQ-039 rst_n pulsed low mid-SCAN -> no tiro_ok, INIT sweep restarts, municao=16 afterward.
